alu_scheduler: RTL

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 27 ++
 rtl/alu_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU scheduler and its ALU.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB = 6'd1;
  localparam logic [OP_W-1:0] OP_AND = 6'd2;
  localparam logic [OP_W-1:0] OP_OR  = 6'd3;
  localparam logic [OP_W-1:0] OP_SLT = 6'd4;
  localparam logic [OP_W-1:0] OP_MUL = 6'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // MUL is the only opcode that takes the multi-cycle path
  function automatic logic op_is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB/AND/OR/unsigned SLT/MUL (low word), all wrap mod 2^32.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y,
  output logic              err
);

  // Opcode decode; anything outside the defined set yields zero and flags an error
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SLT:  y = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_MUL:  y = a * b;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto a single ALU, one operation in flight at a time.
// MUL results appear MUL_LAT cycles after accept, everything else after one cycle.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 3  // legal 2..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              prio_q;     // port preferred when both request

  logic              gnt_id;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic [TAG_W-1:0]  sel_tag;

  // Latched operation (data path, not reset)
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [OP_W-1:0]   op_p0;
  logic [TAG_W-1:0]  tag_p0;
  logic              id_p0;

  logic [DATA_W-1:0] alu_y;
  logic              alu_err;

  // Grant selection: a lone requester wins, a tie goes to the priority pointer
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = prio_q;
    else if (req1_valid)          gnt_id = 1'b1;
    else                          gnt_id = 1'b0;
  end

  assign req0_ready = !rst && (state_q == IDLE) && req0_valid && (gnt_id == 1'b0);
  assign req1_ready = !rst && (state_q == IDLE) && req1_valid && (gnt_id == 1'b1);
  assign accept     = req0_ready || req1_ready;

  // Operand mux toward the latch registers
  always_comb begin
    sel_a   = req0_a;
    sel_b   = req0_b;
    sel_op  = req0_op;
    sel_tag = req0_tag;
    if (gnt_id) begin
      sel_a   = req1_a;
      sel_b   = req1_b;
      sel_op  = req1_op;
      sel_tag = req1_tag;
    end
  end

  // Control FSM: IDLE accepts, BUSY counts MUL latency, DONE holds until handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            prio_q <= ~gnt_id;
            if (op_is_mul(sel_op)) begin
              state_q <= BUSY;
              cnt_q   <= CNT_LOAD;
            end else begin
              state_q <= DONE;
            end
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // ---- stage p0: operation latched on accept, held until the next accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= sel_a;
      b_p0   <= sel_b;
      op_p0  <= sel_op;
      tag_p0 <= sel_tag;
      id_p0  <= gnt_id;
    end
  end

  alu u_alu (
    .a   (a_p0),
    .b   (b_p0),
    .op  (op_p0),
    .y   (alu_y),
    .err (alu_err)
  );

  // The latched registers cannot change outside IDLE, so while in DONE the
  // response is a stable view of the ALU; it reads zero in every other state.
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = rsp_valid ? alu_y   : '0;
  assign rsp_err    = rsp_valid ? alu_err : 1'b0;
  assign rsp_id     = rsp_valid ? id_p0   : 1'b0;
  assign rsp_tag    = rsp_valid ? tag_p0  : '0;

endmodule
